// File: rtl/tx_arbiter_if.sv
// Bundle of requester, TX engine and RX engine signals around tx_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface tx_arbiter_if #(
  parameter int NSHIFT   = 2,
  parameter int CMD_BITS = 2
);
  logic                s_reserve;
  logic                s_valid;
  logic [CMD_BITS-1:0] s_cmd;
  logic                s_reply_wanted;
  logic                s_started;
  logic [NSHIFT-1:0]   s_data;
  logic                s_data_next;
  logic                s_done;

  logic                p_valid;
  logic [CMD_BITS-1:0] p_cmd;
  logic                p_reply_wanted;
  logic                p_started;
  logic [NSHIFT-1:0]   p_data;
  logic                p_data_next;
  logic                p_done;

  logic                tx_command_valid;
  logic [CMD_BITS-1:0] tx_command;
  logic                tx_command_started;
  logic [NSHIFT-1:0]   tx_data;
  logic                tx_data_next;
  logic                tx_done;

  logic                rx_done;
  logic                rx_owner_s;
  logic                rx_owner_p;
  logic                busy;

  modport slave (
    input  s_reserve, s_valid, s_cmd, s_reply_wanted, s_data,
    output s_started, s_data_next, s_done,
    input  p_valid, p_cmd, p_reply_wanted, p_data,
    output p_started, p_data_next, p_done,
    output tx_command_valid, tx_command, tx_data,
    input  tx_command_started, tx_data_next, tx_done,
    input  rx_done,
    output rx_owner_s, rx_owner_p, busy
  );

  modport master (
    output s_reserve, s_valid, s_cmd, s_reply_wanted, s_data,
    input  s_started, s_data_next, s_done,
    output p_valid, p_cmd, p_reply_wanted, p_data,
    input  p_started, p_data_next, p_done,
    input  tx_command_valid, tx_command, tx_data,
    output tx_command_started, tx_data_next, tx_done,
    output rx_done,
    input  rx_owner_s, rx_owner_p, busy
  );
endinterface

// File: rtl/tx_arbiter.sv
// Two-requester (scheduler/prefetcher) arbiter for the serial TX channel with reply steering.
// Define TX_ARB_RR_EN to alternate grants on collisions instead of fixed scheduler priority.
//
// state      | meaning
// IDLE       | channel free, arbitrate between eligible requesters
// CMD        | owner's command presented to TX engine, waiting for start
// DATA       | owner's payload forwarded until TX engine signals done
// WAIT_REPLY | reply outstanding for owner, no new grants until rx_done
module tx_arbiter #(
  parameter int NSHIFT   = 2,
  parameter int CMD_BITS = 2
) (
  input logic         clk,
  input logic         reset,
  tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_REPLY} state_t;

  state_t state, state_d;
  logic   owner, owner_d;
  logic   reply_pending, reply_pending_d;
  logic   s_elig, p_elig, grant_p;

  assign s_elig = bus.s_valid;
  assign p_elig = bus.p_valid && !bus.s_reserve;

`ifdef TX_ARB_RR_EN
  logic last_winner, last_winner_d;

  // On a collision, favour whoever lost the previous grant.
  assign grant_p = p_elig && (!s_elig || !last_winner);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_winner <= 1'b1;
    else        last_winner <= last_winner_d;
  end
`else
  assign grant_p = p_elig && !s_elig;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      reply_pending <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      reply_pending <= reply_pending_d;
    end
  end

  always_comb begin
    state_d              = state;
    owner_d              = owner;
    reply_pending_d      = reply_pending;
`ifdef TX_ARB_RR_EN
    last_winner_d        = last_winner;
`endif
    bus.tx_command_valid = 1'b0;
    bus.tx_command       = '0;
    bus.tx_data          = '0;
    bus.s_started        = 1'b0;
    bus.p_started        = 1'b0;
    bus.s_data_next      = 1'b0;
    bus.p_data_next      = 1'b0;
    bus.s_done           = 1'b0;
    bus.p_done           = 1'b0;
    bus.rx_owner_s       = 1'b0;
    bus.rx_owner_p       = 1'b0;
    bus.busy             = (state != IDLE);

    case (state)
      IDLE: begin
        if (s_elig || p_elig) begin
          state_d         = CMD;
          owner_d         = grant_p;
          reply_pending_d = grant_p ? bus.p_reply_wanted : bus.s_reply_wanted;
`ifdef TX_ARB_RR_EN
          last_winner_d   = grant_p;
`endif
        end
      end

      CMD: begin
        bus.tx_command_valid = 1'b1;
        bus.tx_command       = owner ? bus.p_cmd : bus.s_cmd;
        if (bus.tx_command_started) begin
          bus.s_started = !owner;
          bus.p_started = owner;
          state_d       = DATA;
        end else if (!(owner ? bus.p_valid : bus.s_valid)) begin
          state_d = IDLE;
        end
      end

      DATA: begin
        bus.tx_data     = owner ? bus.p_data : bus.s_data;
        bus.s_data_next = !owner && bus.tx_data_next;
        bus.p_data_next = owner && bus.tx_data_next;
        if (bus.tx_done) begin
          bus.s_done = !owner;
          bus.p_done = owner;
          state_d    = reply_pending ? WAIT_REPLY : IDLE;
        end
      end

      WAIT_REPLY: begin
        bus.rx_owner_s = !owner;
        bus.rx_owner_p = owner;
        if (bus.rx_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter; collision expectations follow TX_ARB_RR_EN when defined.
module tb_tx_arbiter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic last_w;

  tx_arbiter_if #(.NSHIFT(2), .CMD_BITS(2)) bus ();

  tx_arbiter #(.NSHIFT(2), .CMD_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction starting in the IDLE cycle in which the owner's valid is seen.
  task automatic xfer(input logic own, input logic [1:0] cmd, input logic rw,
                      input int nchunks, input logic merge_done, input string tag);
    if (own) begin
      bus.p_valid = 1'b1; bus.p_cmd = cmd; bus.p_reply_wanted = rw;
    end else begin
      bus.s_valid = 1'b1; bus.s_cmd = cmd; bus.s_reply_wanted = rw;
    end
    settle();
    chk({tag, "_idle_cmdv"}, bus.tx_command_valid, 1'b0);
    cyc();
    last_w = own;
    bus.s_reply_wanted = 1'b0;
    bus.p_reply_wanted = 1'b0;
    chk({tag, "_cmdv"}, bus.tx_command_valid, 1'b1);
    chk({tag, "_cmd"}, bus.tx_command, cmd);
    chk({tag, "_busy"}, bus.busy, 1'b1);
    bus.tx_command_started = 1'b1;
    settle();
    chk({tag, "_s_started"}, bus.s_started, !own);
    chk({tag, "_p_started"}, bus.p_started, own);
    cyc();
    bus.tx_command_started = 1'b0;
    if (own) bus.p_valid = 1'b0;
    else     bus.s_valid = 1'b0;
    for (int i = 0; i < nchunks; i++) begin
      logic [1:0] d;
      d = 2'(i + 1);
      bus.s_data = own ? ~d : d;
      bus.p_data = own ? d : ~d;
      bus.tx_data_next = 1'b1;
      bus.tx_done = merge_done && (i == nchunks - 1);
      settle();
      chk({tag, "_tx_data"}, bus.tx_data, d);
      chk({tag, "_s_data_next"}, bus.s_data_next, !own);
      chk({tag, "_p_data_next"}, bus.p_data_next, own);
      chk({tag, "_s_done_d"}, bus.s_done, !own && bus.tx_done);
      chk({tag, "_p_done_d"}, bus.p_done, own && bus.tx_done);
      cyc();
    end
    bus.tx_data_next = 1'b0;
    if (!merge_done) begin
      bus.tx_done = 1'b1;
      settle();
      chk({tag, "_s_done"}, bus.s_done, !own);
      chk({tag, "_p_done"}, bus.p_done, own);
      cyc();
    end
    bus.tx_done = 1'b0;
    settle();
    chk({tag, "_post_busy"}, bus.busy, rw);
    chk({tag, "_post_cmdv"}, bus.tx_command_valid, 1'b0);
    chk({tag, "_post_rx_s"}, bus.rx_owner_s, rw && !own);
    chk({tag, "_post_rx_p"}, bus.rx_owner_p, rw && own);
  endtask

  initial begin
    logic w;
    vectors     = 0;
    miscompares = 0;
    last_w      = 1'b1;
    reset = 1'b0;
    bus.s_reserve = 1'b0; bus.s_valid = 1'b0; bus.s_cmd = '0; bus.s_reply_wanted = 1'b0; bus.s_data = '0;
    bus.p_valid = 1'b0; bus.p_cmd = '0; bus.p_reply_wanted = 1'b0; bus.p_data = '0;
    bus.tx_command_started = 1'b0; bus.tx_data_next = 1'b0; bus.tx_done = 1'b0; bus.rx_done = 1'b0;

    // Reset state, requests held off while reset is low
    cyc();
    bus.s_valid = 1'b1;
    cyc();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cmdv", bus.tx_command_valid, 1'b0);
    chk("rst_cmd", bus.tx_command, 2'd0);
    chk("rst_rx_s", bus.rx_owner_s, 1'b0);
    chk("rst_rx_p", bus.rx_owner_p, 1'b0);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    cyc();

    // Single scheduler transaction, 8 chunks then done, start on second CMD cycle
    bus.s_valid = 1'b1; bus.s_cmd = 2'd2;
    settle();
    chk("t1_no_comb", bus.tx_command_valid, 1'b0);
    cyc();
    chk("t1_cmdv_wait", bus.tx_command_valid, 1'b1);
    chk("t1_no_start", bus.s_started, 1'b0);
    cyc();
    last_w = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_valid = 1'b1;
    // remaining CMD/DATA handled by xfer from the CMD cycle is not possible; hand-drive
    chk("t1_cmd", bus.tx_command, 2'd2);
    bus.tx_command_started = 1'b1;
    settle();
    chk("t1_s_started", bus.s_started, 1'b1);
    chk("t1_p_started", bus.p_started, 1'b0);
    cyc();
    bus.tx_command_started = 1'b0;
    bus.s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] d;
      d = 2'(i);
      bus.s_data = d; bus.p_data = ~d; bus.tx_data_next = 1'b1;
      settle();
      chk("t1_tx_data", bus.tx_data, d);
      chk("t1_s_dn", bus.s_data_next, 1'b1);
      chk("t1_p_dn", bus.p_data_next, 1'b0);
      cyc();
    end
    bus.tx_data_next = 1'b0; bus.tx_done = 1'b1;
    settle();
    chk("t1_s_done", bus.s_done, 1'b1);
    chk("t1_p_done", bus.p_done, 1'b0);
    cyc();
    bus.tx_done = 1'b0;
    settle();
    chk("t1_idle_busy", bus.busy, 1'b0);
    chk("t1_idle_data", bus.tx_data, 2'd0);

    // rx_done in IDLE is ignored
    bus.rx_done = 1'b1;
    cyc();
    bus.rx_done = 1'b0;
    chk("rxd_idle_busy", bus.busy, 1'b0);

    // Collision: winner then loser after one idle cycle, twice
    for (int k = 0; k < 2; k++) begin
`ifdef TX_ARB_RR_EN
      w = !last_w;
`else
      w = 1'b0;
`endif
      bus.s_valid = 1'b1; bus.s_cmd = 2'd1;
      bus.p_valid = 1'b1; bus.p_cmd = 2'd3;
      xfer(w, w ? 2'd3 : 2'd1, 1'b0, 2, 1'b1, "coll_win");
      xfer(!w, w ? 2'd1 : 2'd3, 1'b0, 1, 1'b0, "coll_lose");
    end

    // Reserve blocks the prefetcher; release grants it with a reply pending
    bus.s_reserve = 1'b1; bus.p_valid = 1'b1; bus.p_cmd = 2'd3;
    cyc();
    cyc();
    chk("rsv_busy", bus.busy, 1'b0);
    chk("rsv_cmdv", bus.tx_command_valid, 1'b0);
    bus.s_reserve = 1'b0;
    xfer(1'b1, 2'd3, 1'b1, 3, 1'b1, "rsv_p");

    // Scheduler held off while the prefetcher's reply is outstanding
    bus.s_valid = 1'b1; bus.s_cmd = 2'd2;
    cyc();
    cyc();
    chk("wr_busy", bus.busy, 1'b1);
    chk("wr_cmdv", bus.tx_command_valid, 1'b0);
    chk("wr_rx_p", bus.rx_owner_p, 1'b1);
    bus.rx_done = 1'b1;
    cyc();
    bus.rx_done = 1'b0;
    chk("wr_rel_busy", bus.busy, 1'b0);
    chk("wr_rel_rx_p", bus.rx_owner_p, 1'b0);
    xfer(1'b0, 2'd2, 1'b0, 1, 1'b1, "wr_s");

    // Withdrawal in CMD
    bus.s_valid = 1'b1; bus.s_cmd = 2'd1;
    cyc();
    last_w = 1'b0;
    chk("wd_cmdv", bus.tx_command_valid, 1'b1);
    bus.s_valid = 1'b0;
    settle();
    chk("wd_no_start", bus.s_started, 1'b0);
    cyc();
    chk("wd_idle_cmdv", bus.tx_command_valid, 1'b0);
    chk("wd_idle_busy", bus.busy, 1'b0);

    // Reset in DATA, then a normal prefetch grant
    bus.p_valid = 1'b1; bus.p_cmd = 2'd2;
    cyc();
    bus.tx_command_started = 1'b1;
    cyc();
    bus.tx_command_started = 1'b0; bus.p_valid = 1'b0;
    bus.p_data = 2'd3; bus.tx_data_next = 1'b1;
    settle();
    chk("rd_pre_data", bus.tx_data, 2'd3);
    chk("rd_pre_dn", bus.p_data_next, 1'b1);
    reset = 1'b0;
    bus.tx_done = 1'b1;
    last_w = 1'b1;
    settle();
    chk("rd_data", bus.tx_data, 2'd0);
    chk("rd_dn", bus.p_data_next, 1'b0);
    chk("rd_done", bus.p_done, 1'b0);
    chk("rd_busy", bus.busy, 1'b0);
    cyc();
    bus.tx_done = 1'b0; bus.tx_data_next = 1'b0;
    reset = 1'b1;
    cyc();
    xfer(1'b1, 2'd1, 1'b0, 1, 1'b1, "rd_after");

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
Arbitrates the single serial TX channel between two requesters: the instruction scheduler (port s_*) and the instruction prefetcher (port p_*). Grants one command at a time and forwards payload data and handshakes between the owner and the TX engine. Tracks whether the granted command expects a reply and steers RX reply ownership back to that requester. Sits between the decoder/scheduler, the prefetch unit and the TX/RX engines.

Parameters:
NSHIFT, 2, payload bits moved per tx_data_next cycle
CMD_BITS, 2, width of a TX command (equals TX_CMD_BITS)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
s_reserve  input  1  scheduler will need TX soon; blocks new prefetch grants
s_valid  input  1  scheduler command request
s_cmd  input  CMD_BITS  scheduler command
s_reply_wanted  input  1  scheduler command expects an RX reply
s_started  output  1  one-cycle pulse: scheduler command accepted by TX engine
s_data  input  NSHIFT  scheduler payload
s_data_next  output  1  scheduler payload advance strobe
s_done  output  1  one-cycle pulse: scheduler transmission finished
p_valid, p_cmd, p_reply_wanted, p_started, p_data, p_data_next, p_done  same as s_* for prefetcher
tx_command_valid  output  1  command valid to TX engine
tx_command  output  CMD_BITS  muxed command
tx_command_started  input  1  TX engine accepted command
tx_data  output  NSHIFT  muxed payload
tx_data_next  input  1  TX engine consumed payload chunk
tx_done  input  1  TX engine finished transmission
rx_done  input  1  reply reception finished
rx_owner_s  output  1  outstanding reply belongs to scheduler
rx_owner_p  output  1  outstanding reply belongs to prefetcher
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, CMD, DATA, WAIT_REPLY. Registers: state, owner (0=scheduler, 1=prefetcher), reply_pending, last_winner.
- Reset (reset=0, async): state=IDLE, owner=0, reply_pending=0, last_winner=1. All outputs 0; tx_command and tx_data are 0 when not in CMD/DATA.
- IDLE: grant if s_valid, or if p_valid and !s_reserve. Scheduler wins when both are eligible (fixed priority). On grant, latch owner and the selected reply_wanted, and go to CMD next cycle. No combinational path from s_valid/p_valid to tx_command_valid; grant latency is 1 cycle.
- CMD: tx_command_valid=1 and tx_command=owner's cmd, sampled live from the owner; the requester must hold valid/cmd until started.
  - On tx_command_started, pulse the owner's *_started in the same cycle and go to DATA.
  - If the owner drops valid before started, the request is withdrawn: return to IDLE with no pulse.
- DATA: tx_data=owner's data; owner's *_data_next = tx_data_next, with the non-owner's strobe held 0.
  - On tx_done, pulse the owner's *_done. Then go to WAIT_REPLY if the reply_wanted latch is set, else IDLE.
  - tx_done and tx_data_next in the same cycle: both are forwarded.
- WAIT_REPLY: rx_owner_s/rx_owner_p = decoded owner. On rx_done, go to IDLE.
  - New grants are blocked, so at most one reply is outstanding.
  - rx_done outside WAIT_REPLY is ignored.
- IDLE is re-entered for at least one cycle between transactions, giving back-to-back grants 1 idle cycle of gap.
- s_reserve rising while the prefetcher owns the channel does not abort the transaction. It only affects the next arbitration.
- Reset mid-transaction aborts immediately. Requesters see no done pulse.

Optional Feature:
TX_ARB_RR_EN
- Defined: when both requesters are eligible in IDLE (s_valid, p_valid, !s_reserve), the requester that did not win last time is granted. last_winner updates on every grant.
- s_reserve still forces scheduler priority by making the prefetcher ineligible.
- Undefined: fixed scheduler priority, and last_winner is unused.

Test Plan:
- s_valid=1, s_cmd=2, reply_wanted=0; tx_command_started on 2nd cycle, tx_data_next x8, tx_done -> tx_command_valid high from cycle 1, s_started pulse once, s_data forwarded, s_done pulse, then IDLE with p_* strobes at 0 throughout.
- s_valid and p_valid both asserted in the same IDLE cycle -> scheduler granted, and the prefetcher is granted after s_done plus 1 idle cycle. With TX_ARB_RR_EN, a repeat of the collision grants the prefetcher first.
- p_valid=1 with s_reserve=1 -> no grant. Deassert s_reserve -> p granted the next cycle, tx_command=p_cmd.
- p_reply_wanted=1, full transaction -> busy stays 1 and rx_owner_p=1 after p_done. s_valid is held off until rx_done, then the scheduler is granted 1 cycle later.
- Scheduler owner drops s_valid in CMD before tx_command_started -> return to IDLE, no s_started pulse, tx_command_valid low.
- reset asserted in DATA -> all outputs 0 immediately, state IDLE. After release, p_valid is granted normally.
